aes_encrypt: RTL and testbench

Iterative AES-128 encryption core, the forward-direction counterpart of the lab 9 decryption core. It accepts a 128-bit key and plaintext on a start request and runs the ten FIPS-197 rounds using a multi-cycle FSM. It generates round keys on the fly, one per round, so no stored key schedule is needed. It presents the ciphertext with a level done flag and sits behind the same Avalon-MM register wrapper as the decryptor.

---
 rtl/aes_encrypt_if.sv | 43 ++++
 rtl/aes_encrypt.sv | 176 +++++++++++++++++
 tb/tb_aes_encrypt.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_encrypt_if.sv
// ---------------------------------------------------------------------------
// aes_encrypt_if
// Register-level bus between the Avalon-MM wrapper (master) and the AES-128
// encryption core (slave).
//
// Signals:
//   AES_START     master->slave  level start request
//   AES_KEY       master->slave  128-bit cipher key, byte 0 = [127:120]
//   AES_MSG_PLAIN master->slave  128-bit plaintext,  byte 0 = [127:120]
//   AES_DONE      slave->master  high while the core sits in DONE
//   AES_MSG_ENC   slave->master  ciphertext register
//
// Handshake: this is a level request/acknowledge pair, not a valid/ready
// stream. The core samples AES_KEY and AES_MSG_PLAIN on the first rising
// edge where AES_START is high and the core is idle. AES_DONE then rises
// once the ciphertext is in AES_MSG_ENC. It stays high for as long as
// AES_START is held. AES_START must be seen low for one edge before
// another operation can begin. AES_START is ignored while a block is
// being processed.
// ---------------------------------------------------------------------------
interface aes_encrypt_if;
    logic         AES_START;
    logic         AES_DONE;
    logic [127:0] AES_KEY;
    logic [127:0] AES_MSG_PLAIN;
    logic [127:0] AES_MSG_ENC;

    modport master (
        output AES_START,
        output AES_KEY,
        output AES_MSG_PLAIN,
        input  AES_DONE,
        input  AES_MSG_ENC
    );

    modport slave (
        input  AES_START,
        input  AES_KEY,
        input  AES_MSG_PLAIN,
        output AES_DONE,
        output AES_MSG_ENC
    );
endinterface

// File: rtl/aes_encrypt.sv
// ---------------------------------------------------------------------------
// aes_encrypt
// Iterative AES-128 encryption core. The FSM applies one transformation per
// cycle. Round keys are derived on the fly during SUB_BYTES, so no key
// schedule is stored. Rounds 1-9 take 7 cycles and round 10 takes 3.
// DONE is entered 66 edges after the start edge.
//
// Ports:
//   CLK        system clock, rising edge
//   RESET      synchronous, active-high reset
//   bus        aes_encrypt_if.slave (start/done, key, plaintext, ciphertext)
//   fsm_state  debug view of the FSM state (0 = IDLE, 8 = DONE)
// ---------------------------------------------------------------------------
module aes_encrypt (
    input  logic         CLK,
    input  logic         RESET,
    aes_encrypt_if.slave bus,
    output logic [3:0]   fsm_state
);

    typedef enum logic [3:0] {
        IDLE          = 4'd0,
        SUB_BYTES     = 4'd1,
        SHIFT_ROWS    = 4'd2,
        MIX_COL_0     = 4'd3,
        MIX_COL_1     = 4'd4,
        MIX_COL_2     = 4'd5,
        MIX_COL_3     = 4'd6,
        ADD_ROUND_KEY = 4'd7,
        DONE          = 4'd8
    } state_t;

    // Forward S-box. Element 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t       fsm;
    logic [127:0] st;
    logic [127:0] rk;
    logic [3:0]   round;
    logic [127:0] enc_q;

    assign fsm_state       = fsm;
    assign bus.AES_DONE    = (fsm == DONE);
    assign bus.AES_MSG_ENC = enc_q;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = SBOX[s[8*i +: 8]];
        return o;
    endfunction

    // Byte (row r, col c) lives at [127-32c-8r -: 8]; row r rotates left by r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-32*c-8*r -: 8] = s[127-32*((c+r)%4)-8*r -: 8];
        return o;
    endfunction

    // 3*b is computed as xtime(b) ^ b.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // SubWord(RotWord(w3)) folded into a single expression.
    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fsm   <= IDLE;
            st    <= '0;
            rk    <= '0;
            round <= '0;
            enc_q <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (bus.AES_START) begin
                        st    <= bus.AES_MSG_PLAIN ^ bus.AES_KEY;
                        rk    <= bus.AES_KEY;
                        round <= 4'd1;
                        fsm   <= SUB_BYTES;
                    end
                end
                SUB_BYTES: begin
                    // The round key for this round is produced alongside SubBytes.
                    st  <= sub_bytes(st);
                    rk  <= next_key(rk, rcon(round));
                    fsm <= SHIFT_ROWS;
                end
                SHIFT_ROWS: begin
                    st  <= shift_rows(st);
                    // The final round has no MixColumns.
                    fsm <= (round < 4'd10) ? MIX_COL_0 : ADD_ROUND_KEY;
                end
                MIX_COL_0: begin
                    st[127:96] <= mix_column(st[127:96]);
                    fsm        <= MIX_COL_1;
                end
                MIX_COL_1: begin
                    st[95:64] <= mix_column(st[95:64]);
                    fsm       <= MIX_COL_2;
                end
                MIX_COL_2: begin
                    st[63:32] <= mix_column(st[63:32]);
                    fsm       <= MIX_COL_3;
                end
                MIX_COL_3: begin
                    st[31:0] <= mix_column(st[31:0]);
                    fsm      <= ADD_ROUND_KEY;
                end
                ADD_ROUND_KEY: begin
                    st <= st ^ rk;
                    if (round == 4'd10) begin
                        enc_q <= st ^ rk;
                        fsm   <= DONE;
                    end else begin
                        round <= round + 4'd1;
                        fsm   <= SUB_BYTES;
                    end
                end
                DONE: begin
                    if (!bus.AES_START) fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encrypt.sv
// ---------------------------------------------------------------------------
// tb_aes_encrypt
// Self-checking bench for aes_encrypt. The reference model is a textbook
// AES-128 with a full 44-word key expansion. Its S-box is computed from the
// GF(2^8) inverse plus the affine map. The model also has an inverse cipher
// for round-trip checks.
// ---------------------------------------------------------------------------
module tb_aes_encrypt;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    // ---------------- clock / reset ----------------
    logic       CLK;
    logic       RESET;
    logic [3:0] fsm_state;

    aes_encrypt_if bus();

    aes_encrypt dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  sb  [256];
    logic [7:0]  isb [256];
    logic [31:0] ks  [44];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, x[7:0]);
            if (x == 0) inv = 8'h00;
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x]  = s;
            isb[s] = x[7:0];
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) ks[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = ks[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            ks[i] = ks[i-4] ^ t;
        end
    endtask

    // Byte i of a block is (row i%4, col i/4), located at [127-8i -: 8].
    function automatic logic [127:0] model_enc(input logic [127:0] pt);
        logic [127:0] s, t;
        logic [7:0]   a [4];
        s = pt ^ {ks[0], ks[1], ks[2], ks[3]};
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sb[s[127-8*i -: 8]];
            t = s;
            for (int i = 0; i < 16; i++)
                s[127-8*i -: 8] = t[127-8*((((i/4)+(i%4))%4)*4 + i%4) -: 8];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[j] = s[127-8*(4*c+j) -: 8];
                    for (int j = 0; j < 4; j++)
                        s[127-8*(4*c+j) -: 8] = gmul(a[j], 8'h02) ^ gmul(a[(j+1)%4], 8'h03)
                                              ^ a[(j+2)%4] ^ a[(j+3)%4];
                end
            end
            s = s ^ {ks[4*r], ks[4*r+1], ks[4*r+2], ks[4*r+3]};
        end
        return s;
    endfunction

    function automatic logic [127:0] model_dec(input logic [127:0] ct);
        logic [127:0] s, t;
        logic [7:0]   a [4];
        s = ct ^ {ks[40], ks[41], ks[42], ks[43]};
        for (int r = 10; r >= 1; r--) begin
            t = s;
            for (int i = 0; i < 16; i++)
                s[127-8*i -: 8] = t[127-8*((((i/4)+4-(i%4))%4)*4 + i%4) -: 8];
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = isb[s[127-8*i -: 8]];
            s = s ^ {ks[4*(r-1)], ks[4*(r-1)+1], ks[4*(r-1)+2], ks[4*(r-1)+3]};
            if (r > 1) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[j] = s[127-8*(4*c+j) -: 8];
                    for (int j = 0; j < 4; j++)
                        s[127-8*(4*c+j) -: 8] = gmul(a[j], 8'h0e) ^ gmul(a[(j+1)%4], 8'h0b)
                                              ^ gmul(a[(j+2)%4], 8'h0d) ^ gmul(a[(j+3)%4], 8'h09);
                end
            end
        end
        return s;
    endfunction

    // ---------------- driver tasks ----------------
    // Returns just after the edge that samples AES_START.
    task automatic start_op(input logic [127:0] key, input logic [127:0] pt);
        @(negedge CLK);
        bus.AES_KEY       = key;
        bus.AES_MSG_PLAIN = pt;
        bus.AES_START     = 1'b1;
        @(posedge CLK);
    endtask

    // Counts edges after the start edge until AES_DONE is seen; bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (n < 200) begin
            @(posedge CLK);
            #1;
            n++;
            if (bus.AES_DONE) break;
        end
    endtask

    task automatic drop_start(input string tag, input logic [127:0] ct);
        @(negedge CLK);
        bus.AES_START = 1'b0;
        @(posedge CLK);
        #1;
        check({tag, "_done_low"}, {127'd0, bus.AES_DONE}, 128'd0);
        check({tag, "_idle"}, {124'd0, fsm_state}, 128'd0);
        check({tag, "_ct_hold"}, bus.AES_MSG_ENC, ct);
    endtask

    task automatic run_check(input string tag, input logic [127:0] key, input logic [127:0] pt);
        int n;
        logic [127:0] exp_ct;
        start_op(key, pt);
        wait_done(n);
        exp_ct = exp_q.pop_front();
        check({tag, "_latency"}, 128'(n), 128'd66);
        check({tag, "_ct"}, bus.AES_MSG_ENC, exp_ct);
        drop_start(tag, exp_ct);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int stable;
        logic [127:0] k, p, ct;

        build_sbox();

        RESET             = 1'b1;
        bus.AES_START     = 1'b0;
        bus.AES_KEY       = '0;
        bus.AES_MSG_PLAIN = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_done", {127'd0, bus.AES_DONE}, 128'd0);
        check("rst_ct", bus.AES_MSG_ENC, 128'd0);
        check("rst_idle", {124'd0, fsm_state}, 128'd0);
        @(negedge CLK);
        RESET = 1'b0;

        // All-zero key and plaintext.
        exp_q.push_back(CT_Z);
        run_check("zero", '0, '0);

        // FIPS-197 App. B, then hold START high for 200 cycles.
        start_op(KEY_B, PT_B);
        wait_done(n);
        check("appb_latency", 128'(n), 128'd66);
        check("appb_ct", bus.AES_MSG_ENC, CT_B);
        stable = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge CLK);
            #1;
            if (bus.AES_DONE && bus.AES_MSG_ENC == CT_B) stable++;
        end
        check("hold_stable", 128'(stable), 128'd200);
        drop_start("appb", CT_B);

        // C.1 with inputs scrambled right after sampling; old ciphertext must hold mid-run.
        start_op(KEY_C, PT_C);
        @(negedge CLK);
        bus.AES_KEY       = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.AES_MSG_PLAIN = {$urandom(), $urandom(), $urandom(), $urandom()};
        repeat (29) @(posedge CLK);
        #1;
        check("midrun_ct_hold", bus.AES_MSG_ENC, CT_B);
        wait_done(n);
        check("c1_latency", 128'(n + 29), 128'd66);
        check("c1_ct", bus.AES_MSG_ENC, CT_C);
        drop_start("c1", CT_C);

        // Reset at cycle 30 of an encryption aborts it and clears the output.
        start_op(KEY_B, PT_B);
        repeat (29) @(posedge CLK);
        @(negedge CLK);
        RESET         = 1'b1;
        bus.AES_START = 1'b0;
        @(posedge CLK);
        #1;
        check("abort_done", {127'd0, bus.AES_DONE}, 128'd0);
        check("abort_ct", bus.AES_MSG_ENC, 128'd0);
        check("abort_idle", {124'd0, fsm_state}, 128'd0);
        @(negedge CLK);
        RESET = 1'b0;
        exp_q.push_back(CT_C);
        run_check("after_rst", KEY_C, PT_C);

        // Random key/plaintext pairs against the model, plus inverse-cipher round trip.
        for (int i = 0; i < 100; i++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            p = {$urandom(), $urandom(), $urandom(), $urandom()};
            expand_key(k);
            exp_q.push_back(model_enc(p));
            start_op(k, p);
            wait_done(n);
            ct = exp_q.pop_front();
            check("rand_ct", bus.AES_MSG_ENC, ct);
            check("rand_roundtrip", model_dec(bus.AES_MSG_ENC), p);
            @(negedge CLK);
            bus.AES_START = 1'b0;
            @(posedge CLK);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
